// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per clock.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request; accepted in IDLE or DONE, ignored while busy
//   dividend     numerator, sampled only on the accepting edge
//   divisor      denominator, sampled only on the accepting edge
//   busy         high while iterating
//   done         one-cycle completion pulse
//   quotient     result quotient, held until the next completion
//   remainder    result remainder, held until the next completion
//   div_by_zero  set when the most recent completed operation had divisor == 0
//
// A non-zero divide takes WIDTH iterations after the accepting edge, then one
// DONE cycle in which a new start may be accepted. A zero divisor completes
// on the accepting edge itself and never raises busy.

module seq_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    // The partial remainder is always strictly less than the divisor once an
    // iteration commits, so its top bit is provably zero and only the low
    // WIDTH bits are stored. The trial subtraction is still WIDTH+1 wide.
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Shift the next dividend bit into the partial remainder and try to
    // subtract the divisor; a clear sign bit means the subtraction fits.
    always_comb begin
        shifted = {p_q, q_q[WIDTH-1]};
        trial   = shifted - {1'b0, div_q};
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    div_d = divisor;
                    q_d   = dividend;
                    p_d   = '0;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        // Resolved immediately; no iterations are run.
                        quot_d  = '1;
                        rem_d   = dividend;
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StRun;
                    end
                end else begin
                    state_d = StIdle;
                end
            end

            StRun: begin
                if (!trial[WIDTH]) begin
                    p_d = trial[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    p_d = shifted[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    quot_d  = q_d;
                    rem_d   = p_d;
                    dz_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            p_q     <= '0;
            q_q     <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    // busy and done decode straight from the state register, so they are
    // glitch-free and mutually exclusive by construction.
    always_comb begin
        busy        = (state_q == StRun);
        done        = (state_q == StDone);
        quotient    = quot_q;
        remainder   = rem_q;
        div_by_zero = dz_q;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH = 16): directed vector table,
// hand-written multi-cycle sequences, and a bounded random regression.

module tb_seq_divider;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int passed = 0;
    int total  = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
        logic         exp_dz;
        string        name;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Called at the negedge after the accepting edge; returns the number of
    // further edges until done is seen, and whether busy stayed high meanwhile.
    task automatic wait_done(output int lat, output bit busy_ok, output bit overlap);
        lat = 0;
        busy_ok = 1'b1;
        overlap = 1'b0;
        while (!done && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy && done) overlap = 1'b1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz, input string name);
        int lat;
        bit busy_ok, overlap;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        // Operands may change freely after acceptance.
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        wait_done(lat, busy_ok, overlap);
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_latency"}, 32'(lat), edz ? 32'd0 : 32'(W));
        check({name, "_busy_run"}, 32'(busy_ok), 32'd1);
        check({name, "_busy_done_overlap"}, 32'(overlap), 32'd0);
        check({name, "_quotient"}, 32'(quotient), 32'(eq));
        check({name, "_remainder"}, 32'(remainder), 32'(er));
        check({name, "_dz"}, 32'(div_by_zero), 32'(edz));
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        bit busy_ok, overlap, saw_done;
        logic [W-1:0] ra, rb;

        vecs[0]  = '{16'd100,   16'd7,      16'd14,    16'd2,    1'b0, "v100_7"};
        vecs[1]  = '{16'hFFFF,  16'h0001,   16'hFFFF,  16'h0000, 1'b0, "vffff_1"};
        vecs[2]  = '{16'h0003,  16'h000A,   16'h0000,  16'h0003, 1'b0, "v3_10"};
        vecs[3]  = '{16'hFFFF,  16'hFFFF,   16'h0001,  16'h0000, 1'b0, "vffff_ffff"};
        vecs[4]  = '{16'd5,     16'd0,      16'hFFFF,  16'd5,    1'b1, "v5_0"};
        vecs[5]  = '{16'd9,     16'd3,      16'd3,     16'd0,    1'b0, "v9_3"};
        vecs[6]  = '{16'd50000, 16'd3,      16'd16666, 16'd2,    1'b0, "v50000_3"};
        vecs[7]  = '{16'd0,     16'd5,      16'd0,     16'd0,    1'b0, "v0_5"};
        vecs[8]  = '{16'h8000,  16'd3,      16'd10922, 16'd2,    1'b0, "v8000_3"};
        vecs[9]  = '{16'hABCD,  16'h0100,   16'h00AB,  16'h00CD, 1'b0, "vabcd_100"};
        vecs[10] = '{16'd1,     16'd2,      16'd0,     16'd1,    1'b0, "v1_2"};
        vecs[11] = '{16'd0,     16'd0,      16'hFFFF,  16'd0,    1'b1, "v0_0"};

        // Reset state
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp_q, vecs[i].exp_r,
                                 vecs[i].exp_dz, vecs[i].name);

        // start held high across a whole operation: mid-RUN start is ignored,
        // the start still high in the DONE cycle launches a second operation.
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 16'd10;
        start    = 1'b1;
        @(negedge clk);
        dividend = 16'd7;
        divisor  = 16'd7;
        wait_done(lat, busy_ok, overlap);
        check("hold_first_latency", 32'(lat), 32'(W));
        check("hold_first_quotient", 32'(quotient), 32'd100);
        check("hold_first_remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("hold_second_busy", 32'(busy), 32'd1);
        check("hold_second_done_low", 32'(done), 32'd0);
        wait_done(lat, busy_ok, overlap);
        check("hold_second_latency", 32'(lat), 32'(W));
        check("hold_second_busy_run", 32'(busy_ok), 32'd1);
        check("hold_second_quotient", 32'(quotient), 32'd1);
        check("hold_second_remainder", 32'(remainder), 32'd0);
        check("hold_second_dz", 32'(div_by_zero), 32'd0);
        @(negedge clk);

        // Asynchronous reset in the middle of an operation.
        dividend = 16'd50000;
        divisor  = 16'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_dz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        run_op(16'd50000, 16'd3, 16'd16666, 16'd2, 1'b0, "after_abort");

        // Random regression against the language's own / and % operators.
        for (int i = 0; i < 1500; i++) begin
            ra = 16'($urandom);
            rb = (i % 2 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
            @(negedge clk);
            dividend = ra;
            divisor  = rb;
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_done(lat, busy_ok, overlap);
            check("rand_quotient", 32'(quotient), 32'(ra / rb));
            check("rand_remainder", 32'(remainder), 32'(ra % rb));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
